// File: rtl/vec_pkg.sv
// Shared vector-unit types: default vector geometry, the fetch engine state
// encoding and the assembled vector type used by the vector register file.
package vec_pkg;

    localparam int unsigned VEC_LANES      = 4;
    localparam int unsigned VEC_DATA_W     = 32;
    localparam int unsigned VEC_ELEM_BYTES = 4;

    // Lane k occupies bits [k*VEC_DATA_W +: VEC_DATA_W]
    typedef logic [VEC_LANES-1:0][VEC_DATA_W-1:0] vec_t;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        REQ,
        WAIT,
        OUT
    } ldv_state_t;

endpackage

// File: rtl/ldv_fetch.sv
// Vector-load fetch engine: turns an LDV (row i, column j, dimension n) into
// LANES sequential single-word memory reads and hands back the assembled vector.
module ldv_fetch
    import vec_pkg::*;
#(
    parameter int unsigned       LANES      = VEC_LANES,
    parameter int unsigned       DATA_W     = VEC_DATA_W,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       ELEM_BYTES = VEC_ELEM_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ldv_start,
    input  logic [31:0]             i_in,
    input  logic [31:0]             j_in,
    input  logic [31:0]             n_in,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rd_data,
    input  logic                    mem_rd_valid,
    output logic [LANES*DATA_W-1:0] vec_data,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    busy
);

    localparam int unsigned      LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    ldv_state_t state_reg, state_next;

    logic [31:0]       i_reg, j_reg, n_reg;
    logic [63:0]       idx0_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] vec_reg [LANES];

    logic [31:0]       row_w;
    logic [63:0]       idx0_calc;
    logic [ADDR_W-1:0] addr_lane;
    logic              capture;
    logic [LANES-1:0]  lane_we;

    // n+1 wraps in 32 bits, so n = all-ones collapses idx0 to j
    assign row_w     = n_reg + 32'd1;
    assign idx0_calc = ({32'd0, i_reg} * {32'd0, row_w}) + {32'd0, j_reg};
    assign addr_lane = ADDR_W'(64'(BASE_ADDR) + (idx0_reg + 64'(lane_reg)) * 64'(ELEM_BYTES));

    // Read data is only meaningful while a request is outstanding
    assign capture = (state_reg == WAIT) && mem_rd_valid;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (ldv_start) state_next = CALC;
            CALC: state_next = REQ;
            REQ:  state_next = WAIT;
            WAIT: begin
                if (mem_rd_valid) begin
                    state_next = (lane_reg == LAST_LANE) ? OUT : REQ;
                end
            end
            OUT:  if (vec_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            i_reg         <= '0;
            j_reg         <= '0;
            n_reg         <= '0;
            idx0_reg      <= '0;
            lane_reg      <= '0;
            addr_hold_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && ldv_start) begin
                i_reg <= i_in;
                j_reg <= j_in;
                n_reg <= n_in;
            end
            if (state_reg == CALC) begin
                idx0_reg <= idx0_calc;
                lane_reg <= '0;
            end
            if (state_reg == REQ) begin
                addr_hold_reg <= addr_lane;
            end
            if (capture && lane_reg != LAST_LANE) begin
                lane_reg <= lane_reg + LANE_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_we[gi] = capture && (lane_reg == LANE_W'(gi));
            assign vec_data[gi*DATA_W +: DATA_W] = vec_reg[gi];
        end
    endgenerate

    // Slots keep the previous vector until overwritten lane by lane
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) vec_reg[k] <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_we[k]) vec_reg[k] <= mem_rd_data;
            end
        end
    end

    assign mem_rd_en = (state_reg == REQ);
    assign mem_addr  = (state_reg == REQ) ? addr_lane : addr_hold_reg;
    assign vec_valid = (state_reg == OUT);
    assign busy      = (state_reg != IDLE);

endmodule
